// File: rtl/hit_miss_scoreboard_if.sv
// Packet-side signals seen by the scoreboard: issue strobe, golden result
// and the intersection unit's delayed answer.
interface hit_miss_scoreboard_if;
    logic in_valid;
    logic ref_hit;
    logic hit_miss;

    modport master (output in_valid, output ref_hit, output hit_miss);
    modport slave  (input  in_valid, input  ref_hit, input  hit_miss);
endinterface

// File: rtl/hit_miss_scoreboard.sv
// On-chip Type1/Type2 error counter for the ray/box intersection unit: golden
// hit bits ride a LATENCY-deep delay line and meet hit_miss at its tail.
module hit_miss_scoreboard #(
    parameter int LATENCY = 42,
    parameter int N_RAYS  = 10000,
    parameter int T1_W    = 10,
    parameter int T2_W    = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    hit_miss_scoreboard_if.slave  bus,
    output logic [T1_W-1:0]       type1_err,
    output logic [T2_W-1:0]       type2_err,
    output logic [CNT_W-1:0]      compared,
    output logic                  mismatch,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [LATENCY-1:0] vld_pipe;
    logic [LATENCY-1:0] ref_pipe;
    logic               tail_vld, tail_ref, cmp_en;

    assign tail_vld = vld_pipe[LATENCY-1];
    assign tail_ref = ref_pipe[LATENCY-1];
    assign done     = (state == S_DONE);

    // Valid bits gate everything, so only they need reset; once done, new
    // packets are refused but in-flight ones keep draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= bus.in_valid & ~done & ~clear;
            for (int i = 1; i < LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1] & ~clear;
        end
    end

    always_ff @(posedge clk) begin
        ref_pipe[0] <= bus.ref_hit;
        for (int i = 1; i < LATENCY; i++)
            ref_pipe[i] <= ref_pipe[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmp_en    = tail_vld && (state != S_DONE);
        if (clear) begin
            state_nxt = S_IDLE;
        end else if (cmp_en) begin
            state_nxt = (compared == CNT_W'(N_RAYS - 1)) ? S_DONE : S_RUN;
        end
    end

    // Late results after done still pulse mismatch but move no counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            compared  <= '0;
            type1_err <= '0;
            type2_err <= '0;
            mismatch  <= 1'b0;
        end else if (clear) begin
            compared  <= '0;
            type1_err <= '0;
            type2_err <= '0;
            mismatch  <= 1'b0;
        end else begin
            mismatch <= tail_vld & (tail_ref != bus.hit_miss);
            if (cmp_en) begin
                compared <= compared + CNT_W'(1);
                if (tail_ref && !bus.hit_miss && type1_err != '1)
                    type1_err <= type1_err + T1_W'(1);
                if (!tail_ref && bus.hit_miss && type2_err != '1)
                    type2_err <= type2_err + T2_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hit_miss_scoreboard.sv
// Directed bench for hit_miss_scoreboard with LATENCY=4, N_RAYS=8, T1_W=2.
module tb_hit_miss_scoreboard;
    localparam int LAT = 4;
    localparam int NR  = 8;
    localparam int T1W = 2;
    localparam int T2W = 16;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic [T1W-1:0] type1_err;
    logic [T2W-1:0] type2_err;
    logic [CW-1:0]  compared;
    logic           mismatch;
    logic           done;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] mm_vec;
    int          mm_cnt;
    int          done_step;

    always #5 clk = ~clk;

    hit_miss_scoreboard_if bus ();

    hit_miss_scoreboard #(
        .LATENCY(LAT), .N_RAYS(NR), .T1_W(T1W), .T2_W(T2W), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .type1_err(type1_err), .type2_err(type2_err), .compared(compared),
        .mismatch(mismatch), .done(done)
    );

    task automatic step(input logic v, input logic r, input logic h, input logic c);
        bus.in_valid = v;
        bus.ref_hit  = r;
        bus.hit_miss = h;
        clear        = c;
        @(posedge clk);
        #1;
    endtask

    // Packet p is issued on step p; h_cyc is the hit_miss value per step.
    // Mismatch seen after step c belongs to packet c-LAT.
    task automatic run_stream(input int n_pkt, input logic [31:0] v,
                              input logic [31:0] r, input logic [31:0] h_cyc);
        mm_vec = '0;
        mm_cnt = 0;
        done_step = -1;
        for (int c = 0; c < n_pkt + LAT; c++) begin
            step(c < n_pkt ? v[c] : 1'b0, c < n_pkt ? r[c] : 1'b0, h_cyc[c], 1'b0);
            if (mismatch) begin
                mm_cnt++;
                if (c >= LAT) mm_vec[c-LAT] = 1'b1;
            end
            if (done && done_step < 0) done_step = c;
        end
    endtask

    task automatic do_clear();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.ref_hit = 1'b0; bus.hit_miss = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (compared !== 16'd0)  begin fails++; $display("FAIL reset_compared got=%0d exp=0", compared); end
        checks++; if (type1_err !== 2'd0)  begin fails++; $display("FAIL reset_t1 got=%0d exp=0", type1_err); end
        checks++; if (type2_err !== 16'd0) begin fails++; $display("FAIL reset_t2 got=%0d exp=0", type2_err); end
        checks++; if (mismatch !== 1'b0)   begin fails++; $display("FAIL reset_mismatch got=%b exp=0", mismatch); end
        checks++; if (done !== 1'b0)       begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clean_run();
        run_stream(8, 32'hFF, 32'hB2, 32'hB2 << LAT);
        checks++; if (compared !== 16'd8)  begin fails++; $display("FAIL clean_compared got=%0d exp=8", compared); end
        checks++; if (type1_err !== 2'd0)  begin fails++; $display("FAIL clean_t1 got=%0d exp=0", type1_err); end
        checks++; if (type2_err !== 16'd0) begin fails++; $display("FAIL clean_t2 got=%0d exp=0", type2_err); end
        checks++; if (mm_cnt !== 0)        begin fails++; $display("FAIL clean_mm_pulses got=%0d exp=0", mm_cnt); end
        checks++; if (done_step !== 11)    begin fails++; $display("FAIL clean_done_step got=%0d exp=11", done_step); end
    endtask

    task automatic test_pattern();
        do_clear();
        run_stream(8, 32'hFF, 32'h53, 32'hC6 << LAT);
        checks++; if (type1_err !== 2'd2)  begin fails++; $display("FAIL pattern_t1 got=%0d exp=2", type1_err); end
        checks++; if (type2_err !== 16'd2) begin fails++; $display("FAIL pattern_t2 got=%0d exp=2", type2_err); end
        checks++; if (mm_cnt !== 4)        begin fails++; $display("FAIL pattern_mm_pulses got=%0d exp=4", mm_cnt); end
        checks++; if (mm_vec !== 32'h95)   begin fails++; $display("FAIL pattern_mm_align got=%h exp=95", mm_vec); end
        checks++; if (compared !== 16'd8)  begin fails++; $display("FAIL pattern_compared got=%0d exp=8", compared); end
    endtask

    task automatic test_gapped();
        do_clear();
        run_stream(8, 32'h59, 32'h11, 32'hAAAAAAAA);
        checks++; if (compared !== 16'd4)  begin fails++; $display("FAIL gapped_compared got=%0d exp=4", compared); end
        checks++; if (type1_err !== 2'd2)  begin fails++; $display("FAIL gapped_t1 got=%0d exp=2", type1_err); end
        checks++; if (type2_err !== 16'd1) begin fails++; $display("FAIL gapped_t2 got=%0d exp=1", type2_err); end
        checks++; if (mm_vec !== 32'h19)   begin fails++; $display("FAIL gapped_mm_align got=%h exp=19", mm_vec); end
        checks++; if (done !== 1'b0)       begin fails++; $display("FAIL gapped_done got=%b exp=0", done); end
    endtask

    task automatic test_saturate();
        do_clear();
        run_stream(5, 32'h1F, 32'h1F, 32'h0);
        checks++; if (type1_err !== 2'd3)  begin fails++; $display("FAIL sat_t1 got=%0d exp=3", type1_err); end
        checks++; if (mm_cnt !== 5)        begin fails++; $display("FAIL sat_mm_pulses got=%0d exp=5", mm_cnt); end
        checks++; if (compared !== 16'd5)  begin fails++; $display("FAIL sat_compared got=%0d exp=5", compared); end
        checks++; if (type2_err !== 16'd0) begin fails++; $display("FAIL sat_t2 got=%0d exp=0", type2_err); end
    endtask

    task automatic test_done_overflow();
        do_clear();
        run_stream(10, 32'h3FF, 32'h335, 32'h035 << LAT);
        checks++; if (compared !== 16'd8)  begin fails++; $display("FAIL ovf_compared got=%0d exp=8", compared); end
        checks++; if (type1_err !== 2'd0)  begin fails++; $display("FAIL ovf_t1 got=%0d exp=0", type1_err); end
        checks++; if (done !== 1'b1)       begin fails++; $display("FAIL ovf_done got=%b exp=1", done); end
        checks++; if (done_step !== 11)    begin fails++; $display("FAIL ovf_done_step got=%0d exp=11", done_step); end
        do_clear();
        checks++; if (compared !== 16'd0)  begin fails++; $display("FAIL clr_compared got=%0d exp=0", compared); end
        checks++; if (done !== 1'b0)       begin fails++; $display("FAIL clr_done got=%b exp=0", done); end
        checks++; if (mismatch !== 1'b0)   begin fails++; $display("FAIL clr_mismatch got=%b exp=0", mismatch); end
        run_stream(3, 32'h7, 32'h5, 32'h5 << LAT);
        checks++; if (compared !== 16'd3)  begin fails++; $display("FAIL rerun_compared got=%0d exp=3", compared); end
        checks++; if (done !== 1'b0)       begin fails++; $display("FAIL rerun_done got=%b exp=0", done); end
    endtask

    task automatic test_reset_inflight();
        int pulses;
        pulses = 0;
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (compared !== 16'd0)  begin fails++; $display("FAIL rst_async_compared got=%0d exp=0", compared); end
        checks++; if (done !== 1'b0)       begin fails++; $display("FAIL rst_async_done got=%b exp=0", done); end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (mismatch) pulses++;
        end
        checks++; if (compared !== 16'd0)  begin fails++; $display("FAIL rst_drain_compared got=%0d exp=0", compared); end
        checks++; if (type2_err !== 16'd0) begin fails++; $display("FAIL rst_drain_t2 got=%0d exp=0", type2_err); end
        checks++; if (pulses !== 0)        begin fails++; $display("FAIL rst_drain_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_clear_collision();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (compared !== 16'd1)  begin fails++; $display("FAIL coll_pre_compared got=%0d exp=1", compared); end
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (compared !== 16'd0)  begin fails++; $display("FAIL coll_compared got=%0d exp=0", compared); end
        checks++; if (type1_err !== 2'd0)  begin fails++; $display("FAIL coll_t1 got=%0d exp=0", type1_err); end
        checks++; if (mismatch !== 1'b0)   begin fails++; $display("FAIL coll_mismatch got=%b exp=0", mismatch); end
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (compared !== 16'd0)  begin fails++; $display("FAIL coll_discard_compared got=%0d exp=0", compared); end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_pattern();
        test_gapped();
        test_saturate();
        test_done_overflow();
        test_reset_inflight();
        test_clear_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hit_miss_scoreboard.md
# hit_miss_scoreboard

Synthesizable result-side checker for the Ray_AABB_11_12 intersection pipeline. It records each issued ray/box packet's golden hit bit together with a valid flag, delays both by the unit's pipeline latency, compares them against `hit_miss`, and accumulates Type1 and Type2 error counts on-chip. It sits beside the stimulus feeder, so reduced-precision units can be characterised in hardware without a simulator-side comparator.

## Interface
- `LATENCY`, default 42: cycles from a packet being sampled at the unit's inputs to its `hit_miss` being valid; must be ≥1.
- `N_RAYS`, default 10000: number of comparisons per run.
- `T1_W`, default 10: width of the Type1 counter.
- `T2_W`, default 16: width of the Type2 counter.
- `CNT_W`, default 16: width of the compared counter; must satisfy 2^CNT_W > N_RAYS.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous run restart.
- `in_valid`  in  1  packet presented to the intersection unit this cycle.
- `ref_hit`  in  1  high-precision golden result for that packet.
- `hit_miss`  in  1  intersection unit output.
- `type1_err`  out  T1_W  golden hit, unit reported miss.
- `type2_err`  out  T2_W  golden miss, unit reported hit.
- `compared`  out  CNT_W  comparisons performed this run.
- `mismatch`  out  1  one-cycle pulse on any disagreement.
- `done`  out  1  sticky; high once `compared` == N_RAYS.

## Operation
- Delay line: LATENCY-deep shift register of {valid, ref}.
  - Stage 0 loads {`in_valid & ~done`, `ref_hit`} every cycle.
  - The tail is the compare slot.
- Compare, when tail valid = 1:
  - `compared` += 1.
  - tail ref = 1 and `hit_miss` = 0 → `type1_err` += 1.
  - tail ref = 0 and `hit_miss` = 1 → `type2_err` += 1.
  - `mismatch` = (tail ref != `hit_miss`); otherwise `mismatch` = 0.
- When tail valid = 0: `hit_miss` is ignored, no counter moves, `mismatch` = 0.
- Error counters saturate at all-ones; further errors are still pulsed on `mismatch`.
- `done`:
  - Set on the edge where `compared` becomes N_RAYS.
  - While `done` = 1, stage 0 loads valid = 0 (new packets are refused).
  - Packets already in flight still compare, but `compared` stops at N_RAYS and counters freeze. Late results are not counted.
- `clear` = 1:
  - Next edge zeroes all counters, `mismatch`, `done` and every delay-line valid bit.
  - A compare pending that cycle is discarded.
  - `in_valid` in the same cycle is also discarded (stage 0 valid = 0).
- Run states, implied by `compared` and `done`:
  - IDLE: `compared` = 0, `done` = 0.
  - RUN: `compared` > 0.
  - DONE: `done` = 1.
  - RUN→DONE on the N_RAYS-th compare; any state → IDLE on `clear` or reset.

## Timing
- `in_valid`/`ref_hit` sampled at edge t are compared with `hit_miss` sampled at edge t+LATENCY. This matches the unit registering its inputs at t.
- Counter, `mismatch` and `done` updates are registered outputs, visible after edge t+LATENCY. There is no combinational path from inputs to outputs.
- Throughput: one comparison per cycle, back-to-back, with no bubbles required.
- Reset values, asynchronous on `rst_n` low: all outputs 0 and all delay-line valid bits 0.
- Reset asserted mid-run: in-flight packets are lost. After release the block is in IDLE and the first valid compare occurs LATENCY cycles after the first new `in_valid`.
- Ref bits need no reset; only valid bits gate behaviour.

## Test plan
Benches use LATENCY=4, N_RAYS=8, T1_W=2 unless stated.
- Reset, then 8 consecutive `in_valid`, with `hit_miss` driven equal to the delayed `ref_hit` → `compared` = 8, both error counters 0, `done` rises exactly 4 cycles after the last `in_valid` edge, `mismatch` never pulses.
- Pattern ref = 1,1,0,0,1,0,1,0 with `hit_miss` = 0,1,1,0,0,0,1,1 → `type1_err` = 2, `type2_err` = 2, four single-cycle `mismatch` pulses aligned to the stream.
- Gapped stream (`in_valid` = 1,0,0,1,…) with `hit_miss` toggling every cycle → only valid slots counted; `compared` equals the number of valid packets issued.
- 5 Type1 errors with T1_W = 2 → `type1_err` saturates at 3 while `mismatch` pulses 5 times.
- 10 packets issued with N_RAYS = 8 → `done` after the 8th compare; `compared` stays at 8 and counters ignore packets 9–10. Then assert `clear` → all outputs 0, and a new run counts normally.
- `rst_n` pulsed low with 3 packets in flight → outputs 0 immediately; no compare occurs in the following 4 cycles without new `in_valid`. Separately, `clear` asserted in the same cycle as a tail-valid mismatch → counters 0 and no `mismatch` pulse.
